// File: rtl/accel_spi_pkg.sv
// Shared definitions for the accelerometer SPI responder.
// Holds the transaction state enum, command bytes, register addresses and
// the soft-reset key used by spi_accel_responder.
package accel_spi_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DATA_WR,
    S_DATA_RD,
    S_IGNORE
  } spi_state_e;

  localparam logic [7:0] CMD_WRITE = 8'h0A;
  localparam logic [7:0] CMD_READ  = 8'h0B;

  localparam logic [5:0] REG_DEVID_AD      = 6'h00;
  localparam logic [5:0] REG_DEVID_MST     = 6'h01;
  localparam logic [5:0] REG_PARTID        = 6'h02;
  localparam logic [5:0] REG_XDATA         = 6'h08;
  localparam logic [5:0] REG_YDATA         = 6'h09;
  localparam logic [5:0] REG_ZDATA         = 6'h0A;
  localparam logic [5:0] REG_SOFT_RESET    = 6'h1F;
  localparam logic [5:0] REG_SCRATCH_FIRST = 6'h20;
  localparam logic [5:0] REG_SCRATCH_LAST  = 6'h2C;
  localparam logic [5:0] REG_POWER_CTL     = 6'h2D;

  localparam int SCRATCH_DEPTH = 13;

  localparam logic [7:0] SOFT_RESET_KEY = 8'h52;

  function automatic logic is_scratch(input logic [5:0] a);
    return (a >= REG_SCRATCH_FIRST) && (a <= REG_SCRATCH_LAST);
  endfunction

endpackage

// File: rtl/spi_slave_shifter.sv
// SPI mode-0 bit engine running in the system clock domain.
// Synchronizes sclk/cs/mosi, detects edges, assembles received bytes and
// shifts transmit bytes out MSB first on sclk falling edges.
// Ports:
//   clk, reset        system clock, async active-low reset
//   sclk, cs, mosi    raw SPI pins
//   tx_load, tx_byte  load the next byte to transmit (wins over a shift)
//   busy              selected: set by a cs fall, cleared when cs is high
//   cs_fall, cs_rise  one-clk pulses on synchronized cs edges
//   byte_valid        one-clk pulse, rx_byte holds a complete byte
//   miso              registered serial output bit
module spi_slave_shifter #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sclk,
  input  logic       cs,
  input  logic       mosi,
  input  logic       tx_load,
  input  logic [7:0] tx_byte,
  output logic       busy,
  output logic       cs_fall,
  output logic       cs_rise,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       miso
);

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   sclk_d, cs_d;
  logic                   sel;
  logic [2:0]             bit_cnt;
  logic [6:0]             rx_shift;
  logic [7:0]             tx_shift;
  logic                   sclk_rise, sclk_fall;

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  // cs resets to "low" so that a pin still held low when reset releases
  // produces no fall; a transaction starts only after cs is seen high first.
  assign cs_fall   = cs_d & ~cs_s;
  assign cs_rise   = ~cs_d & cs_s;
  assign sclk_rise = sel & ~cs_s & sclk_s & ~sclk_d;
  assign sclk_fall = sel & ~cs_s & ~sclk_s & sclk_d;
  assign busy      = sel;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_sync  <= '0;
      cs_sync    <= '0;
      mosi_sync  <= '0;
      sclk_d     <= 1'b0;
      cs_d       <= 1'b0;
      sel        <= 1'b0;
      bit_cnt    <= 3'd0;
      rx_shift   <= 7'd0;
      rx_byte    <= 8'd0;
      byte_valid <= 1'b0;
      tx_shift   <= 8'd0;
      miso       <= 1'b0;
    end else begin
      sclk_sync  <= (sclk_sync << 1) | SYNC_STAGES'(sclk);
      cs_sync    <= (cs_sync << 1) | SYNC_STAGES'(cs);
      mosi_sync  <= (mosi_sync << 1) | SYNC_STAGES'(mosi);
      sclk_d     <= sclk_s;
      cs_d       <= cs_s;
      byte_valid <= 1'b0;

      if (cs_fall) sel <= 1'b1;
      else if (cs_s) sel <= 1'b0;

      // Partial bytes are dropped whenever the slave is deselected.
      if (!sel || cs_s) begin
        bit_cnt <= 3'd0;
      end else if (sclk_rise) begin
        rx_shift <= {rx_shift[5:0], mosi_s};
        bit_cnt  <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          byte_valid <= 1'b1;
          rx_byte    <= {rx_shift, mosi_s};
        end
      end

      if (cs_fall || cs_rise) begin
        tx_shift <= 8'd0;
        miso     <= 1'b0;
      end else if (tx_load) begin
        tx_shift <= tx_byte;
      end else if (sclk_fall) begin
        miso     <= tx_shift[7];
        tx_shift <= {tx_shift[6:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/spi_accel_responder.sv
// SPI slave emulating the accelerometer register interface.
// Command byte (0x0A write / 0x0B read), address byte, then auto-incrementing
// data bytes. Sensor values are snapshotted at cs fall (zero when not
// measuring). Handshake: byte_valid from the shifter is a single-clk pulse
// with rx_byte valid in the same cycle; tx_load is a single-clk pulse with
// tx_byte valid in that cycle, no backpressure in either direction.
// Ports:
//   clk, reset               system clock, async active-low reset
//   sclk, cs, mosi, miso     SPI pins, miso_oe high while selected
//   xData, yData, zData      live sensor values
//   measuring                POWER_CTL[1:0] == 2'b10
//   wr_strobe/addr/data      one-clk pulse and payload per committed write
//   busy                     slave is selected
module spi_accel_responder
  import accel_spi_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] DEVID_AD    = 8'hAD,
  parameter logic [7:0] DEVID_MST   = 8'h1D,
  parameter logic [7:0] PARTID      = 8'hF2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sclk,
  input  logic       cs,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  input  logic [7:0] xData,
  input  logic [7:0] yData,
  input  logic [7:0] zData,
  output logic       measuring,
  output logic       wr_strobe,
  output logic [5:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy
);

  spi_state_e state, state_next;

  logic       cs_fall, cs_rise, byte_valid, shift_miso;
  logic [7:0] rx_byte;
  logic       tx_load;
  logic [7:0] tx_byte;
  logic       commit;

  logic       wr_mode;
  logic [5:0] addr;
  logic [7:0] x_shadow, y_shadow, z_shadow;
  logic [7:0] power_ctl;
  logic [7:0] scratch [SCRATCH_DEPTH];
  logic       soft_pend;

  logic [5:0] rd_addr;
  logic [7:0] rd_data;
  logic [3:0] rd_idx, wr_idx;

  spi_slave_shifter #(.SYNC_STAGES(SYNC_STAGES)) u_shifter (
    .clk        (clk),
    .reset      (reset),
    .sclk       (sclk),
    .cs         (cs),
    .mosi       (mosi),
    .tx_load    (tx_load),
    .tx_byte    (tx_byte),
    .busy       (busy),
    .cs_fall    (cs_fall),
    .cs_rise    (cs_rise),
    .byte_valid (byte_valid),
    .rx_byte    (rx_byte),
    .miso       (shift_miso)
  );

  assign miso_oe   = busy;
  assign miso      = shift_miso & (state == S_DATA_RD);
  assign measuring = (power_ctl[1:0] == 2'b10);

  // The ADDR byte selects the first register; in DATA_RD the next one is
  // prefetched while the current byte is still on the wire.
  assign rd_addr = (state == S_ADDR) ? rx_byte[5:0] : addr + 6'd1;
  assign rd_idx  = 4'(rd_addr - REG_SCRATCH_FIRST);
  assign wr_idx  = 4'(addr - REG_SCRATCH_FIRST);

  always_comb begin
    rd_data = 8'h00;
    case (rd_addr)
      REG_DEVID_AD:  rd_data = DEVID_AD;
      REG_DEVID_MST: rd_data = DEVID_MST;
      REG_PARTID:    rd_data = PARTID;
      REG_XDATA:     rd_data = x_shadow;
      REG_YDATA:     rd_data = y_shadow;
      REG_ZDATA:     rd_data = z_shadow;
      REG_POWER_CTL: rd_data = power_ctl;
      default:       if (is_scratch(rd_addr)) rd_data = scratch[rd_idx];
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    tx_load    = 1'b0;
    tx_byte    = 8'h00;
    commit     = 1'b0;
    case (state)
      S_IDLE:    if (cs_fall) state_next = S_CMD;
      S_CMD:     if (byte_valid)
                   state_next = (rx_byte == CMD_WRITE || rx_byte == CMD_READ) ? S_ADDR : S_IGNORE;
      S_ADDR:    if (byte_valid) begin
                   if (wr_mode) begin
                     state_next = S_DATA_WR;
                   end else begin
                     state_next = S_DATA_RD;
                     tx_load    = 1'b1;
                     tx_byte    = rd_data;
                   end
                 end
      S_DATA_WR: commit = byte_valid;
      S_DATA_RD: if (byte_valid) begin
                   tx_load = 1'b1;
                   tx_byte = rd_data;
                 end
      default:   ;
    endcase
    if (cs_rise) begin
      state_next = S_IDLE;
      tx_load    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_mode   <= 1'b0;
      addr      <= 6'd0;
      x_shadow  <= 8'd0;
      y_shadow  <= 8'd0;
      z_shadow  <= 8'd0;
      power_ctl <= 8'd0;
      soft_pend <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= 6'd0;
      wr_data   <= 8'd0;
      for (int i = 0; i < SCRATCH_DEPTH; i++) scratch[i] <= 8'd0;
    end else begin
      wr_strobe <= 1'b0;
      soft_pend <= 1'b0;

      if (state == S_IDLE && cs_fall) begin
        x_shadow <= measuring ? xData : 8'h00;
        y_shadow <= measuring ? yData : 8'h00;
        z_shadow <= measuring ? zData : 8'h00;
      end
      if (state == S_CMD && byte_valid) wr_mode <= (rx_byte == CMD_WRITE);
      if (state == S_ADDR && byte_valid) addr <= rx_byte[5:0];
      if (state == S_DATA_RD && byte_valid) addr <= addr + 6'd1;

      // Writes to read-only or unmapped addresses still strobe.
      if (commit) begin
        wr_strobe <= 1'b1;
        wr_addr   <= addr;
        wr_data   <= rx_byte;
        addr      <= addr + 6'd1;
        if (addr == REG_POWER_CTL) power_ctl <= rx_byte;
        if (is_scratch(addr)) scratch[wr_idx] <= rx_byte;
        if (addr == REG_SOFT_RESET && rx_byte == SOFT_RESET_KEY) soft_pend <= 1'b1;
      end

      if (soft_pend) begin
        power_ctl <= 8'd0;
        for (int i = 0; i < SCRATCH_DEPTH; i++) scratch[i] <= 8'd0;
      end
    end
  end

endmodule

// File: tb/tb_spi_accel_responder.sv
module tb_spi_accel_responder;

  localparam int HALF = 8;  // sclk half period in clk cycles

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sclk = 1'b0;
  logic       cs = 1'b1;
  logic       mosi = 1'b0;
  logic       miso, miso_oe, measuring, wr_strobe, busy;
  logic [7:0] xData = 8'h00, yData = 8'h00, zData = 8'h00;
  logic [5:0] wr_addr;
  logic [7:0] wr_data;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  exp_q[$];
  logic [13:0] wr_log_q[$];
  int          miso_hi_cnt = 0;
  logic [7:0]  tx_buf[8];
  logic [7:0]  rx_buf[8];

  spi_accel_responder dut (
    .clk       (clk),
    .reset     (reset),
    .sclk      (sclk),
    .cs        (cs),
    .mosi      (mosi),
    .miso      (miso),
    .miso_oe   (miso_oe),
    .xData     (xData),
    .yData     (yData),
    .zData     (zData),
    .measuring (measuring),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  // write and miso monitors
  always @(negedge clk) begin
    if (wr_strobe === 1'b1) wr_log_q.push_back({wr_addr, wr_data});
    if (miso === 1'b1) miso_hi_cnt++;
  end

  // driver tasks
  task automatic spi_byte(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i >= 8 - nbits; i--) begin
      mosi = tx[i];
      repeat (HALF) @(negedge clk);
      rx[i] = miso;
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  task automatic spi_txn(input int nbytes, input int tail_bits);
    logic [7:0] r;
    cs = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int b = 0; b < nbytes; b++) begin
      spi_byte(tx_buf[b], 8, r);
      rx_buf[b] = r;
    end
    if (tail_bits > 0) begin
      spi_byte(tx_buf[nbytes], tail_bits, r);
      rx_buf[nbytes] = r;
    end
    repeat (HALF) @(negedge clk);
    cs = 1'b1;
    mosi = 1'b0;
    repeat (2 * HALF) @(negedge clk);
  endtask

  task automatic set3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    tx_buf[0] = a; tx_buf[1] = b; tx_buf[2] = c;
    for (int i = 3; i < 8; i++) tx_buf[i] = 8'h00;
  endtask

  // tests
  task automatic test_reset;
    reset = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++; if (miso !== 1'b0) begin n_errors++; $display("FAIL reset_miso got=%b exp=0", miso); end
    n_checks++; if (miso_oe !== 1'b0) begin n_errors++; $display("FAIL reset_miso_oe got=%b exp=0", miso_oe); end
    n_checks++; if (measuring !== 1'b0) begin n_errors++; $display("FAIL reset_measuring got=%b exp=0", measuring); end
    n_checks++; if (wr_strobe !== 1'b0) begin n_errors++; $display("FAIL reset_wr_strobe got=%b exp=0", wr_strobe); end
    n_checks++; if (wr_addr !== 6'h00) begin n_errors++; $display("FAIL reset_wr_addr got=%h exp=00", wr_addr); end
    n_checks++; if (wr_data !== 8'h00) begin n_errors++; $display("FAIL reset_wr_data got=%h exp=00", wr_data); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    reset = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_busy;
    cs = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++; if (busy !== 1'b1 || miso_oe !== 1'b1) begin n_errors++; $display("FAIL busy_sel got=%b%b exp=11", busy, miso_oe); end
    cs = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++; if (busy !== 1'b0 || miso_oe !== 1'b0) begin n_errors++; $display("FAIL busy_desel got=%b%b exp=00", busy, miso_oe); end
    repeat (HALF) @(negedge clk);
  endtask

  task automatic test_write_power;
    wr_log_q.delete();
    set3(8'h0A, 8'h2D, 8'h02);
    spi_txn(3, 0);
    n_checks++; if (wr_log_q.size() != 1) begin n_errors++; $display("FAIL wp_count got=%0d exp=1", wr_log_q.size()); end
    else begin
      n_checks++; if (wr_log_q[0] !== {6'h2D, 8'h02}) begin n_errors++; $display("FAIL wp_payload got=%h exp=%h", wr_log_q[0], {6'h2D, 8'h02}); end
    end
    n_checks++; if (measuring !== 1'b1) begin n_errors++; $display("FAIL wp_measuring got=%b exp=1", measuring); end
  endtask

  task automatic test_read_xdata;
    logic [7:0] e;
    xData = 8'h5A; yData = 8'h11; zData = 8'h22;
    set3(8'h0B, 8'h08, 8'h00);
    exp_q.push_back(8'h5A);
    spi_txn(3, 0);
    e = exp_q.pop_front();
    n_checks++; if (rx_buf[2] !== e) begin n_errors++; $display("FAIL rx_meas got=%h exp=%h", rx_buf[2], e); end
    set3(8'h0A, 8'h2D, 8'h00);
    spi_txn(3, 0);
    n_checks++; if (measuring !== 1'b0) begin n_errors++; $display("FAIL rx_meas_off got=%b exp=0", measuring); end
    set3(8'h0B, 8'h08, 8'h00);
    exp_q.push_back(8'h00);
    spi_txn(3, 0);
    e = exp_q.pop_front();
    n_checks++; if (rx_buf[2] !== e) begin n_errors++; $display("FAIL rx_idle got=%h exp=%h", rx_buf[2], e); end
  endtask

  task automatic test_burst;
    logic [7:0] e;
    set3(8'h0B, 8'h00, 8'h00);
    exp_q.push_back(8'hAD); exp_q.push_back(8'h1D); exp_q.push_back(8'hF2);
    spi_txn(5, 0);
    for (int b = 2; b < 5; b++) begin
      e = exp_q.pop_front();
      n_checks++; if (rx_buf[b] !== e) begin n_errors++; $display("FAIL burst_b%0d got=%h exp=%h", b, rx_buf[b], e); end
    end
    set3(8'h0B, 8'h3F, 8'h00);
    exp_q.push_back(8'h00); exp_q.push_back(8'hAD);
    spi_txn(4, 0);
    for (int b = 2; b < 4; b++) begin
      e = exp_q.pop_front();
      n_checks++; if (rx_buf[b] !== e) begin n_errors++; $display("FAIL wrap_b%0d got=%h exp=%h", b, rx_buf[b], e); end
    end
  endtask

  task automatic test_abort;
    logic [7:0] e;
    wr_log_q.delete();
    set3(8'h0A, 8'h2D, 8'h02);
    spi_txn(2, 4);
    n_checks++; if (wr_log_q.size() != 0) begin n_errors++; $display("FAIL abort_strobe got=%0d exp=0", wr_log_q.size()); end
    n_checks++; if (measuring !== 1'b0) begin n_errors++; $display("FAIL abort_measuring got=%b exp=0", measuring); end
    set3(8'h0B, 8'h01, 8'h00);
    exp_q.push_back(8'h1D); exp_q.push_back(8'hF2);
    spi_txn(4, 0);
    for (int b = 2; b < 4; b++) begin
      e = exp_q.pop_front();
      n_checks++; if (rx_buf[b] !== e) begin n_errors++; $display("FAIL abort_next_b%0d got=%h exp=%h", b, rx_buf[b], e); end
    end
  endtask

  task automatic test_ignore_soft_reset;
    logic [7:0] e;
    wr_log_q.delete();
    miso_hi_cnt = 0;
    set3(8'h0D, 8'h08, 8'h00);
    spi_txn(3, 0);
    n_checks++; if (miso_hi_cnt != 0 || rx_buf[2] !== 8'h00) begin n_errors++; $display("FAIL ign_miso got=%0d/%h exp=0/00", miso_hi_cnt, rx_buf[2]); end
    n_checks++; if (wr_log_q.size() != 0) begin n_errors++; $display("FAIL ign_strobe got=%0d exp=0", wr_log_q.size()); end
    set3(8'h0A, 8'h2D, 8'h02);
    spi_txn(3, 0);
    tx_buf[0] = 8'h0A; tx_buf[1] = 8'h20; tx_buf[2] = 8'h33; tx_buf[3] = 8'h44;
    spi_txn(4, 0);
    set3(8'h0A, 8'h00, 8'h11);
    spi_txn(3, 0);
    n_checks++; if (wr_log_q.size() != 4) begin n_errors++; $display("FAIL sw_count got=%0d exp=4", wr_log_q.size()); end
    else begin
      n_checks++; if (wr_log_q[2] !== {6'h21, 8'h44}) begin n_errors++; $display("FAIL sw_incr got=%h exp=%h", wr_log_q[2], {6'h21, 8'h44}); end
      n_checks++; if (wr_log_q[3] !== {6'h00, 8'h11}) begin n_errors++; $display("FAIL sw_ro got=%h exp=%h", wr_log_q[3], {6'h00, 8'h11}); end
    end
    set3(8'h0B, 8'h20, 8'h00);
    exp_q.push_back(8'h33); exp_q.push_back(8'h44);
    spi_txn(4, 0);
    for (int b = 2; b < 4; b++) begin
      e = exp_q.pop_front();
      n_checks++; if (rx_buf[b] !== e) begin n_errors++; $display("FAIL scr_b%0d got=%h exp=%h", b, rx_buf[b], e); end
    end
    set3(8'h0B, 8'h00, 8'h00);
    exp_q.push_back(8'hAD);
    spi_txn(3, 0);
    e = exp_q.pop_front();
    n_checks++; if (rx_buf[2] !== e) begin n_errors++; $display("FAIL ro_keep got=%h exp=%h", rx_buf[2], e); end
    n_checks++; if (measuring !== 1'b1) begin n_errors++; $display("FAIL pre_sr_measuring got=%b exp=1", measuring); end
    set3(8'h0A, 8'h1F, 8'h52);
    spi_txn(3, 0);
    n_checks++; if (measuring !== 1'b0) begin n_errors++; $display("FAIL sr_measuring got=%b exp=0", measuring); end
    set3(8'h0B, 8'h1F, 8'h00);
    exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    spi_txn(4, 0);
    for (int b = 2; b < 4; b++) begin
      e = exp_q.pop_front();
      n_checks++; if (rx_buf[b] !== e) begin n_errors++; $display("FAIL sr_read_b%0d got=%h exp=%h", b, rx_buf[b], e); end
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] r, e;
    set3(8'h0A, 8'h2D, 8'h02);
    spi_txn(3, 0);
    wr_log_q.delete();
    cs = 1'b0;
    repeat (HALF) @(negedge clk);
    spi_byte(8'h0B, 8, r);
    spi_byte(8'h00, 8, r);
    spi_byte(8'h00, 3, r);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (measuring !== 1'b0) begin n_errors++; $display("FAIL rm_measuring got=%b exp=0", measuring); end
    n_checks++; if ({miso, miso_oe, busy, wr_strobe} !== 4'b0000) begin n_errors++; $display("FAIL rm_bits got=%b exp=0000", {miso, miso_oe, busy, wr_strobe}); end
    n_checks++; if (wr_addr !== 6'h00 || wr_data !== 8'h00) begin n_errors++; $display("FAIL rm_wr got=%h/%h exp=00/00", wr_addr, wr_data); end
    reset = 1'b1;
    repeat (4) @(negedge clk);
    spi_byte(8'hFF, 5, r);
    repeat (HALF) @(negedge clk);
    cs = 1'b1;
    repeat (2 * HALF) @(negedge clk);
    n_checks++; if (wr_log_q.size() != 0) begin n_errors++; $display("FAIL rm_strobe got=%0d exp=0", wr_log_q.size()); end
    set3(8'h0B, 8'h00, 8'h00);
    exp_q.push_back(8'hAD);
    spi_txn(3, 0);
    e = exp_q.pop_front();
    n_checks++; if (rx_buf[2] !== e) begin n_errors++; $display("FAIL rm_read got=%h exp=%h", rx_buf[2], e); end
  endtask

  initial begin
    test_reset();
    test_busy();
    test_write_power();
    test_read_xdata();
    test_burst();
    test_abort();
    test_ignore_soft_reset();
    test_reset_mid();
    n_checks++; if (exp_q.size() != 0) begin n_errors++; $display("FAIL exp_q_left got=%0d exp=0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_accel_responder.md
Name: spi_accel_responder

Overview:
- SPI mode-0 slave that emulates the accelerometer register interface (write command 0x0A, read command 0x0B, address byte, auto-incrementing data bytes).
- Serves XDATA/YDATA/ZDATA from sensor-value input ports.
- Used as the board-level or simulation counterpart to the accelerometer master, so maze control logic can be exercised without the physical part.
- Oversamples sclk/cs/mosi in the system clock domain; clk must be at least 8x sclk.

Parameters:
- SYNC_STAGES, 2: synchronizer depth on sclk, cs and mosi.
- DEVID_AD, 8'hAD: value read at address 0x00.
- DEVID_MST, 8'h1D: value read at address 0x01.
- PARTID, 8'hF2: value read at address 0x02.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- sclk  in  1  SPI clock from master, idle low
- cs  in  1  chip select, active low
- mosi  in  1  serial data in, MSB first
- miso  out  1  serial data out, MSB first
- miso_oe  out  1  high while selected; board ties miso to high-Z when low
- xData, yData, zData  in  8 each  live sensor values
- measuring  out  1  POWER_CTL[1:0] == 2'b10
- wr_strobe  out  1  one-clk pulse per committed register write
- wr_addr  out  6  address of last committed write
- wr_data  out  8  data of last committed write
- busy  out  1  synchronized cs is low

Behaviour:
- Reset (reset=0, async) outputs: miso=0, miso_oe=0, measuring=0, wr_strobe=0, wr_addr=0, wr_data=0, busy=0. State IDLE, bit counter 0, POWER_CTL=0x00, scratch registers 0x00.
- Inputs pass through SYNC_STAGES flops. Edges of sclk and cs are detected on the synchronized values. Total latency from a pin edge to action is SYNC_STAGES+1 clk.
- Sampling: mosi is sampled on each sclk rising edge. The bit counter increments 0..7; the byte completes on the 8th rising edge.
- Driving: miso changes only on sclk falling edges (and on cs fall for the first bit).
- State machine:
  - IDLE -> CMD on cs fall. Snapshot xData/yData/zData into shadow regs, or 0x00 each if measuring=0.
  - CMD: on byte complete, 0x0A or 0x0B -> ADDR (mode latched). Any other value -> IGNORE.
  - ADDR: on byte complete, latch the 6-bit address (bits [7:6] ignored). Write mode -> DATA_WR. Read mode -> DATA_RD; the register at addr is loaded into the tx shift register and its MSB is driven at the next sclk fall.
  - DATA_WR: each byte complete commits the write, pulses wr_strobe one clk, then addr <= addr+1.
  - DATA_RD: each byte complete does addr <= addr+1 and loads the next register. Its MSB is driven at the next sclk fall.
  - IGNORE: miso held 0, no writes.
  - Any state -> IDLE on cs rise. The partial byte is discarded and the bit counter cleared. A write commits only on a complete byte.
- Register map (6-bit address; others read 0x00, writes ignored):
  - 0x00 DEVID_AD, 0x01 DEVID_MST, 0x02 PARTID: read-only.
  - 0x08 XDATA, 0x09 YDATA, 0x0A ZDATA: read-only, read from the shadow regs.
  - 0x1F SOFT_RESET: writing 0x52 clears POWER_CTL and the scratch registers the cycle after the commit. Reads 0x00.
  - 0x20–0x2C: read/write scratch.
  - 0x2D POWER_CTL: read/write.
- Address wraps 0x3F -> 0x00 in bursts.
- miso_oe = busy. miso=0 whenever not in DATA_RD.
- A write to a read-only address still pulses wr_strobe, but storage is unchanged.
- Async reset mid-transaction: return to IDLE immediately. The transaction resumes only after a fresh cs fall.

Decomposition:
- Package accel_spi_pkg holds:
  - state enum
  - command constants CMD_WRITE=8'h0A, CMD_READ=8'h0B
  - register address constants (XDATA, YDATA, ZDATA, SOFT_RESET, POWER_CTL)
  - SOFT_RESET_KEY=8'h52
- Sub-module spi_slave_shifter: synchronizers, edge detect, rx/tx shift registers, bit counter. It emits byte_valid/rx_byte and accepts tx_load/tx_byte.
- The top level holds the FSM and the register file.

Test Plan:
- Send 0x0A,0x2D,0x02 -> wr_strobe pulses with wr_addr=0x2D, wr_data=0x02; measuring=1 after the commit.
- With measuring=1 and xData=0x5A, send 0x0B,0x08,0x00 -> third byte on miso = 0x5A. With measuring=0, the same transaction returns 0x00.
- Burst read 0x0B,0x00 followed by 3 dummy bytes -> miso bytes 0xAD,0x1D,0xF2. A burst from 0x3F returns reg 0x3F then 0xAD (wrap).
- Write 0x0A,0x2D,0x02 but raise cs after 4 bits of the data byte -> no wr_strobe, measuring stays 0, next transaction decodes normally.
- Command 0x0D,0x08,0x00 -> miso 0 throughout, no wr_strobe. Then write 0x52 to 0x1F after POWER_CTL=0x02 -> measuring=0, and a scratch reg 0x20 previously written 0x33 reads 0x00.
- Assert reset low mid-read -> all outputs at reset values; next full read of 0x00 returns 0xAD.
